// File: rtl/subword_mem_controller.sv
// Bridges CPU loads/stores onto a word-only data memory: lane extraction for
// sub-word loads, read-modify-write sequencing for sub-word stores.
module subword_mem_controller #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_addr_in,
    input  logic [31:0] cpu_wdata_in,
    input  logic        cpu_re_in,
    input  logic        cpu_we_in,
    input  logic [1:0]  cpu_size_in,
    input  logic        cpu_signed_in,
    output logic [31:0] cpu_rdata_out,
    output logic        cpu_stall_out,
    output logic        cpu_misalign_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    output logic [1:0]  mem_size_out,
    input  logic [31:0] mem_rdata_in
);
    typedef enum logic {IDLE, RMW_WRITE} state_t;

    state_t      state;
    logic [29:0] lat_addr;
    logic [31:0] merge;

    logic        is_sub;
    logic        misaligned;
    logic        active;
    logic        lane_sign;
    logic [4:0]  shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_raw;
    logic [31:0] load_value;
    logic [31:0] merged;

    // Lane geometry: mask is right-justified, shift moves it to the addressed lane.
    always_comb begin
        lane_mask  = 32'hFFFF_FFFF;
        shift      = '0;
        misaligned = |cpu_addr_in[1:0];
        case (cpu_size_in)
            2'b00: begin
                lane_mask  = 32'h0000_00FF;
                misaligned = 1'b0;
                shift      = BIG_ENDIAN ? {~cpu_addr_in[1:0], 3'b000}
                                        : { cpu_addr_in[1:0], 3'b000};
            end
            2'b01: begin
                lane_mask  = 32'h0000_FFFF;
                misaligned = cpu_addr_in[0];
                shift      = BIG_ENDIAN ? {~cpu_addr_in[1], 4'b0000}
                                        : { cpu_addr_in[1], 4'b0000};
            end
            default: ;
        endcase
        is_sub     = ~cpu_size_in[1];
        active     = cpu_re_in | cpu_we_in;
        lane_raw   = (mem_rdata_in >> shift) & lane_mask;
        lane_sign  = cpu_size_in[0] ? lane_raw[15] : lane_raw[7];
        load_value = lane_raw;
        if (is_sub && cpu_signed_in && lane_sign) begin
            load_value = lane_raw | ~lane_mask;
        end
        merged = (mem_rdata_in & ~(lane_mask << shift))
               | ((cpu_wdata_in & lane_mask) << shift);
    end

    always_comb begin
        cpu_rdata_out    = '0;
        cpu_stall_out    = 1'b0;
        cpu_misalign_out = 1'b0;
        mem_addr_out     = '0;
        mem_wdata_out    = '0;
        mem_re_out       = 1'b0;
        mem_we_out       = 1'b0;
        mem_size_out     = '0;
        if (!reset) begin
            mem_size_out = 2'b11;
            if (state == RMW_WRITE) begin
                mem_addr_out  = {lat_addr, 2'b00};
                mem_wdata_out = merge;
                mem_we_out    = 1'b1;
            end else begin
                mem_addr_out = {cpu_addr_in[31:2], 2'b00};
                if (active && misaligned) begin
                    cpu_misalign_out = 1'b1;
                end else if (cpu_we_in) begin
                    if (is_sub) begin
                        mem_re_out    = 1'b1;
                        cpu_stall_out = 1'b1;
                    end else begin
                        mem_we_out    = 1'b1;
                        mem_wdata_out = cpu_wdata_in;
                    end
                end else if (cpu_re_in) begin
                    mem_re_out    = 1'b1;
                    cpu_rdata_out = load_value;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            lat_addr <= '0;
            merge    <= '0;
        end else if (state == RMW_WRITE) begin
            state <= IDLE;
        end else if (cpu_we_in && is_sub && !misaligned) begin
            lat_addr <= cpu_addr_in[31:2];
            merge    <= merged;
            state    <= RMW_WRITE;
        end
    end
endmodule
